// File: rtl/pll_rst_supervisor.sv
// rtl/pll_rst_supervisor.sv - PLL reset sequencer with lock timeout/retry, lock qualification and system reset release
// All outputs are registered; lock input is resynchronised to i_refclk before any decision.
module pll_rst_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 8
) (
  input  logic             i_refclk,
  input  logic             i_rst_n,
  input  logic             i_locked,
  output logic             o_pll_rst,
  output logic             o_sys_rst_n,
  output logic             o_ready,
  output logic [CNT_W-1:0] o_retry_cnt,
  output logic [CNT_W-1:0] o_loss_cnt,
  output logic [1:0]       o_state
);

  localparam int MAX_A  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_T  = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int TMR_W  = $clog2(MAX_T + 1);

  localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST     = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {
    S_RESET_PLL = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_sync1;
  logic               r_lk;
  logic [TMR_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_retry_cnt;
  logic [CNT_W-1:0]   r_loss_cnt;
  logic               r_pll_rst;
  logic               r_sys_rst_n;
  logic               r_ready;
  logic               w_retry_inc;
  logic               w_loss_inc;

  // A lock seen on the timeout cycle wins over the retry.
  always_comb begin
    w_next      = r_state;
    w_retry_inc = 1'b0;
    w_loss_inc  = 1'b0;
    case (r_state)
      S_RESET_PLL: begin
        if (r_cnt == RST_LAST) w_next = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (r_lk) begin
          w_next = S_STABLE;
        end else if (r_cnt == TO_LAST) begin
          w_next      = S_RESET_PLL;
          w_retry_inc = 1'b1;
        end
      end
      S_STABLE: begin
        if (!r_lk) w_next = S_WAIT_LOCK;
        else if (r_cnt == STABLE_LAST) w_next = S_RUN;
      end
      S_RUN: begin
        if (!r_lk) begin
          w_next     = S_RESET_PLL;
          w_loss_inc = 1'b1;
        end
      end
      default: w_next = S_RESET_PLL;
    endcase
  end

  always_ff @(posedge i_refclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_RESET_PLL;
      r_sync1     <= 1'b0;
      r_lk        <= 1'b0;
      r_cnt       <= '0;
      r_retry_cnt <= '0;
      r_loss_cnt  <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_sync1 <= i_locked;
      r_lk    <= r_sync1;
      r_state <= w_next;
      if (w_next != r_state) r_cnt <= '0;
      else if (r_state != S_RUN) r_cnt <= r_cnt + TMR_W'(1);
      if (w_retry_inc && (r_retry_cnt != CNT_MAX)) r_retry_cnt <= r_retry_cnt + CNT_W'(1);
      if (w_loss_inc && (r_loss_cnt != CNT_MAX)) r_loss_cnt <= r_loss_cnt + CNT_W'(1);
      // Outputs follow the next state so they change on the same edge as r_state.
      r_pll_rst   <= (w_next == S_RESET_PLL);
      r_sys_rst_n <= (w_next == S_RUN);
      r_ready     <= (w_next == S_RUN);
    end
  end

  assign o_pll_rst   = r_pll_rst;
  assign o_sys_rst_n = r_sys_rst_n;
  assign o_ready     = r_ready;
  assign o_retry_cnt = r_retry_cnt;
  assign o_loss_cnt  = r_loss_cnt;
  assign o_state     = r_state;

endmodule

// File: tb/tb_pll_rst_supervisor.sv
// tb/tb_pll_rst_supervisor.sv - directed self-checking bench for pll_rst_supervisor
// Inputs change and outputs are sampled on the falling edge of refclk.
module tb_pll_rst_supervisor;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int CNT_W         = 4;
  localparam int REL           = 2 + 1 + STABLE_CYCLES;
  localparam int PERIOD        = RST_CYCLES + LOCK_TIMEOUT;
  localparam int SAT           = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             locked = 1'b0;
  logic             pll_rst;
  logic             sys_rst_n;
  logic             ready;
  logic [CNT_W-1:0] retry_cnt;
  logic [CNT_W-1:0] loss_cnt;
  logic [1:0]       state;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_retry_q[$];
  int exp_gap_q[$];

  always #10 clk = ~clk;

  pll_rst_supervisor #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) dut (
    .i_refclk    (clk),
    .i_rst_n     (rst_n),
    .i_locked    (locked),
    .o_pll_rst   (pll_rst),
    .o_sys_rst_n (sys_rst_n),
    .o_ready     (ready),
    .o_retry_cnt (retry_cnt),
    .o_loss_cnt  (loss_cnt),
    .o_state     (state)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input int pll, input int sysn, input int rdy);
    chk({tag, ".state"}, 32'(state), st);
    chk({tag, ".pll_rst"}, 32'(pll_rst), pll);
    chk({tag, ".sys_rst_n"}, 32'(sys_rst_n), sysn);
    chk({tag, ".ready"}, 32'(ready), rdy);
  endtask

  task automatic chk_cnts(input string tag, input int rc, input int lc);
    chk({tag, ".retry_cnt"}, 32'(retry_cnt), rc);
    chk({tag, ".loss_cnt"}, 32'(loss_cnt), lc);
  endtask

  initial begin
    int exp_st;
    int prev_pll;
    int last_rise;
    int e;

    // Reset values
    tick(3);
    chk_all("reset", 0, 1, 0, 0);
    chk_cnts("reset", 0, 0);

    // Test 1: first lock at cycle 10, release REL cycles later
    rst_n = 1'b1;
    for (int c = 0; c <= 24; c++) begin
      if (c < RST_CYCLES) exp_st = 0;
      else if (c < 10 + 3) exp_st = 1;
      else if (c < 10 + REL) exp_st = 2;
      else exp_st = 3;
      chk_all($sformatf("t1.c%0d", c), exp_st, (c < RST_CYCLES) ? 1 : 0,
              (c >= 10 + REL) ? 1 : 0, (c >= 10 + REL) ? 1 : 0);
      if (c == 10) locked = 1'b1;
      tick();
    end
    chk_cnts("t1", 0, 0);

    // Test 4: lock loss in RUN
    locked = 1'b0;
    for (int k = 0; k <= 7; k++) begin
      if (k < 3) chk_all($sformatf("t4.k%0d", k), 3, 0, 1, 1);
      else if (k < 3 + RST_CYCLES) chk_all($sformatf("t4.k%0d", k), 0, 1, 0, 0);
      else chk_all($sformatf("t4.k%0d", k), 1, 0, 0, 0);
      tick();
    end
    chk_cnts("t4", 0, 1);
    locked = 1'b1;
    tick(REL - 1);
    chk_all("t4.relock_pre", 2, 0, 0, 0);
    tick();
    chk_all("t4.relock_run", 3, 0, 1, 1);

    // Test 5: asynchronous reset during RUN
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("t5.async", 0, 1, 0, 0);
    chk_cnts("t5.async", 0, 0);
    locked = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk_all("t5.restart", 0, 1, 0, 0);
    chk_cnts("t5.restart", 0, 0);

    // Test 6: one retry, then lock arrives on the timeout cycle of the second wait
    tick(PERIOD - 1);
    chk_all("t6.retry1", 0, 1, 0, 0);
    chk_cnts("t6.retry1", 1, 0);
    tick(PERIOD - 3);
    locked = 1'b1;
    tick(2);
    chk_all("t6.tocycle", 1, 0, 0, 0);
    tick();
    chk_all("t6.stable", 2, 0, 0, 0);
    chk_cnts("t6.stable", 1, 0);

    // Test 3: 2-cycle drop in STABLE at count 5
    tick(5);
    locked = 1'b0;
    tick(2);
    chk_all("t3.s7", 2, 0, 0, 0);
    locked = 1'b1;
    tick();
    chk_all("t3.s8", 1, 0, 0, 0);
    tick();
    chk_all("t3.s9", 1, 0, 0, 0);
    tick();
    chk_all("t3.s10", 2, 0, 0, 0);
    tick(STABLE_CYCLES - 1);
    chk_all("t3.s17", 2, 0, 0, 0);
    tick();
    chk_all("t3.s18", 3, 0, 1, 1);
    chk_cnts("t3", 1, 0);

    // Test 2: lock lost and never returns; retry pulses and saturation
    locked = 1'b0;
    exp_retry_q.push_back(1);
    exp_gap_q.push_back(3);
    for (int r = 2; r <= SAT; r++) begin
      exp_retry_q.push_back(r);
      exp_gap_q.push_back(PERIOD);
    end
    repeat (2) begin
      exp_retry_q.push_back(SAT);
      exp_gap_q.push_back(PERIOD);
    end
    prev_pll  = 0;
    last_rise = 0;
    for (int cyc = 1; cyc <= 600 && exp_retry_q.size() > 0; cyc++) begin
      tick();
      if (pll_rst === 1'b1 && prev_pll == 0) begin
        e = exp_retry_q.pop_front();
        chk($sformatf("t2.retry@%0d", cyc), 32'(retry_cnt), e);
        e = exp_gap_q.pop_front();
        chk($sformatf("t2.gap@%0d", cyc), cyc - last_rise, e);
        last_rise = cyc;
      end
      prev_pll = (pll_rst === 1'b1) ? 1 : 0;
    end
    chk("t2.drained", exp_retry_q.size(), 0);
    chk_cnts("t2.end", SAT, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
